// File: rtl/piezo_arbiter_pkg.sv
// nap_pkg: owner codes, state encoding and beat constants shared by the piezo arbiter.
package nap_pkg;
  localparam int BEAT_W = 13;
  localparam logic [BEAT_W-1:0] BEAT_MUTE = '0;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_ALARM = 2'd1, OWN_LULL = 2'd2, OWN_BEEP = 2'd3} owner_t;
  typedef enum logic [2:0] {ST_IDLE, ST_GUARD, ST_ALARM, ST_LULL, ST_BEEP} state_t;
  function automatic state_t play_state(owner_t o);
    return o == OWN_ALARM ? ST_ALARM : o == OWN_LULL ? ST_LULL : o == OWN_BEEP ? ST_BEEP : ST_IDLE;
  endfunction
  function automatic owner_t owner_of(state_t s);
    return s == ST_ALARM ? OWN_ALARM : s == ST_LULL ? OWN_LULL : s == ST_BEEP ? OWN_BEEP : OWN_NONE;
  endfunction
endpackage

// File: rtl/piezo_arbiter_down_counter.sv
// arb_down_counter: loadable down counter that saturates at zero and flags it.
module arb_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count <= '0;
    else if (load) count <= load_val;
    else if (en && count != '0) count <= count - 1'b1;
  end
  assign zero = count == '0;
endmodule

// File: rtl/piezo_arbiter.sv
// piezo_arbiter: priority arbiter (alarm > key beep > lullaby) with a silent guard gap between owners.
module piezo_arbiter #(
  parameter int BEAT_W = 13,
  parameter logic [BEAT_W-1:0] KEY_TONE = BEAT_W'(1000),
  parameter int BEEP_CYCLES = 5000000,
  parameter int GUARD_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alarm_req,
  input  logic [BEAT_W-1:0] alarm_beat,
  input  logic              lull_req,
  input  logic [BEAT_W-1:0] lull_beat,
  input  logic              key_pulse,
  input  logic              mute,
  output logic [BEAT_W-1:0] play_sound,
  output logic [1:0]        grant,
  output logic              busy
);
  import nap_pkg::*;
  localparam int MAXC = BEEP_CYCLES > GUARD_CYCLES ? BEEP_CYCLES : GUARD_CYCLES;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  state_t state, next_state;
  owner_t sel;
  logic pend, pend_next, guard_zero, beep_zero, guard_load, beep_load, retrig, enter_beep, silent;
  logic [BEAT_W-1:0] beat;
  always_comb begin
    sel = alarm_req ? OWN_ALARM : pend ? OWN_BEEP : lull_req ? OWN_LULL : OWN_NONE;
    retrig = state == ST_BEEP && key_pulse && !mute;
    next_state = state;
    case (state)
      ST_IDLE:  next_state = play_state(sel);
      ST_GUARD: next_state = guard_zero ? play_state(sel) : ST_GUARD;
      ST_ALARM: next_state = alarm_req ? ST_ALARM : ST_GUARD;
      ST_LULL:  next_state = (alarm_req || pend || !lull_req) ? ST_GUARD : ST_LULL;
      ST_BEEP:  next_state = (alarm_req || (beep_zero && !retrig)) ? ST_GUARD : ST_BEEP;
      default:  next_state = ST_IDLE;
    endcase
    enter_beep = next_state == ST_BEEP && state != ST_BEEP;
    guard_load = next_state == ST_GUARD && state != ST_GUARD;
    beep_load = enter_beep || retrig;
    // Pulses arriving with or during an alarm are dropped; retriggers inside a beep never queue.
    pend_next = (mute || enter_beep) ? 1'b0
              : (key_pulse && !alarm_req && state != ST_ALARM && state != ST_BEEP) ? 1'b1 : pend;
    beat = grant == OWN_ALARM ? alarm_beat : grant == OWN_LULL ? lull_beat
         : grant == OWN_BEEP ? KEY_TONE : BEAT_W'(BEAT_MUTE);
    silent = mute || next_state == ST_GUARD || next_state == ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      pend <= 1'b0;
      grant <= OWN_NONE;
      busy <= 1'b0;
      play_sound <= '0;
    end else begin
      state <= next_state;
      pend <= pend_next;
      grant <= owner_of(next_state);
      busy <= next_state != ST_IDLE;
      play_sound <= silent ? BEAT_W'(BEAT_MUTE) : beat;
    end
  end
  arb_down_counter #(.W(CW)) u_guard (
    .clk(clk), .rst(rst), .load(guard_load), .en(state == ST_GUARD),
    .load_val(CW'(GUARD_CYCLES - 1)), .zero(guard_zero)
  );
  arb_down_counter #(.W(CW)) u_beep (
    .clk(clk), .rst(rst), .load(beep_load), .en(state == ST_BEEP),
    .load_val(CW'(BEEP_CYCLES - 1)), .zero(beep_zero)
  );
endmodule

// File: tb/tb_piezo_arbiter.sv
// tb_piezo_arbiter: directed vector table plus hand-written async reset sequence.
module tb_piezo_arbiter;
  logic clk = 0, rst = 0, alarm_req = 0, lull_req = 0, key_pulse = 0, mute = 0;
  logic [12:0] alarm_beat = 0, lull_beat = 0, play_sound;
  logic [1:0] grant;
  logic busy;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    int n;
    logic a; logic [12:0] ab; logic l; logic [12:0] lb; logic k; logic m;
    logic [12:0] ep; logic [1:0] eg; logic eb;
  } vec_t;
  vec_t vq[$];
  piezo_arbiter #(.BEAT_W(13), .KEY_TONE(13'd1000), .BEEP_CYCLES(10), .GUARD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .alarm_req(alarm_req), .alarm_beat(alarm_beat), .lull_req(lull_req),
    .lull_beat(lull_beat), .key_pulse(key_pulse), .mute(mute), .play_sound(play_sound),
    .grant(grant), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic add(input int n, input logic a, input int ab, input logic l, input int lb,
                     input logic k, input logic m, input int ep, input int eg, input logic eb);
    vec_t v;
    v.n = n; v.a = a; v.ab = 13'(ab); v.l = l; v.lb = 13'(lb); v.k = k; v.m = m;
    v.ep = 13'(ep); v.eg = 2'(eg); v.eb = eb;
    vq.push_back(v);
  endtask
  task automatic outs(input string tag, input int ep, input int eg, input int eb);
    chk({tag, ".play_sound"}, int'(play_sound), ep);
    chk({tag, ".grant"}, int'(grant), eg);
    chk({tag, ".busy"}, int'(busy), eb);
  endtask
  initial begin
    // lullaby start and beat lag
    add(1, 0, 0, 1, 100, 0, 0, 0, 2, 1);
    add(1, 0, 0, 1, 100, 0, 0, 100, 2, 1);
    add(1, 0, 0, 1, 150, 0, 0, 150, 2, 1);
    // alarm preempts through guard, then lullaby resumes
    add(4, 1, 300, 1, 100, 0, 0, 0, 0, 1);
    add(1, 1, 300, 1, 100, 0, 0, 0, 1, 1);
    add(1, 1, 300, 1, 100, 0, 0, 300, 1, 1);
    add(4, 0, 300, 1, 100, 0, 0, 0, 0, 1);
    add(1, 0, 300, 1, 100, 0, 0, 0, 2, 1);
    add(1, 0, 300, 1, 100, 0, 0, 100, 2, 1);
    // single key beep: 10 cycles of grant=3
    add(1, 0, 0, 1, 100, 1, 0, 100, 2, 1);
    add(4, 0, 0, 1, 100, 0, 0, 0, 0, 1);
    add(1, 0, 0, 1, 100, 0, 0, 0, 3, 1);
    add(9, 0, 0, 1, 100, 0, 0, 1000, 3, 1);
    add(4, 0, 0, 1, 100, 0, 0, 0, 0, 1);
    add(1, 0, 0, 1, 100, 0, 0, 0, 2, 1);
    add(1, 0, 0, 1, 100, 0, 0, 100, 2, 1);
    // retriggered beep: 15 cycles of grant=3, no extra beep afterwards
    add(1, 0, 0, 1, 100, 1, 0, 100, 2, 1);
    add(4, 0, 0, 1, 100, 0, 0, 0, 0, 1);
    add(1, 0, 0, 1, 100, 0, 0, 0, 3, 1);
    add(4, 0, 0, 1, 100, 0, 0, 1000, 3, 1);
    add(1, 0, 0, 1, 100, 1, 0, 1000, 3, 1);
    add(9, 0, 0, 1, 100, 0, 0, 1000, 3, 1);
    add(4, 0, 0, 1, 100, 0, 0, 0, 0, 1);
    add(1, 0, 0, 1, 100, 0, 0, 0, 2, 1);
    add(3, 0, 0, 1, 100, 0, 0, 100, 2, 1);
    // alarm + key same cycle, lull falls: one guard pass; pulses during alarm dropped
    add(1, 1, 300, 0, 100, 1, 0, 0, 0, 1);
    add(3, 1, 300, 0, 100, 0, 0, 0, 0, 1);
    add(1, 1, 300, 0, 100, 0, 0, 0, 1, 1);
    add(1, 1, 300, 0, 100, 0, 0, 300, 1, 1);
    add(1, 1, 300, 0, 100, 1, 0, 300, 1, 1);
    add(1, 1, 300, 0, 100, 0, 0, 300, 1, 1);
    add(1, 1, 300, 0, 100, 1, 0, 300, 1, 1);
    add(4, 0, 300, 0, 100, 0, 0, 0, 0, 1);
    add(3, 0, 300, 0, 100, 0, 0, 0, 0, 0);
    // mute silences without changing ownership and blocks beeps
    add(1, 0, 0, 1, 100, 0, 0, 0, 2, 1);
    add(1, 0, 0, 1, 100, 0, 0, 100, 2, 1);
    add(1, 0, 0, 1, 100, 0, 1, 0, 2, 1);
    add(1, 0, 0, 1, 100, 1, 1, 0, 2, 1);
    add(1, 0, 0, 1, 100, 0, 1, 0, 2, 1);
    add(4, 0, 0, 1, 100, 0, 0, 100, 2, 1);
    #2 outs("reset", 0, 0, 0);
    @(negedge clk) rst = 1;
    @(posedge clk) #1 outs("idle_after_reset", 0, 0, 0);
    foreach (vq[i]) for (int r = 0; r < vq[i].n; r++) begin
      @(negedge clk);
      alarm_req = vq[i].a; alarm_beat = vq[i].ab; lull_req = vq[i].l; lull_beat = vq[i].lb;
      key_pulse = vq[i].k; mute = vq[i].m;
      @(posedge clk) #1 outs($sformatf("vec%0d_%0d", i, r), vq[i].ep, vq[i].eg, vq[i].eb);
    end
    // async reset mid-beep
    @(negedge clk) key_pulse = 1;
    @(negedge clk) key_pulse = 0;
    repeat (7) @(posedge clk);
    #1 chk("beep_before_reset.grant", int'(grant), 3);
    chk("beep_before_reset.play_sound", int'(play_sound), 1000);
    #2 rst = 0;
    #1 outs("async_reset", 0, 0, 0);
    lull_req = 0;
    @(negedge clk) rst = 1;
    repeat (5) @(posedge clk);
    #1 outs("idle_after_release", 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
